// File: rtl/conv_layer_seq.sv
// Sequential "same"-padded 2-D convolution layer: one multiply-accumulate per clock,
// start/done handshake, bias, fixed-point shift, dilation, stride, optional ReLU/saturation.
module conv_layer_seq #(
    parameter int IN_DEPTH    = 3,
    parameter int IN_HEIGHT   = 4,
    parameter int IN_WIDTH    = 4,
    parameter int OUT_DEPTH   = 2,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_W      = 16,
    parameter int FRAC        = 4,
    parameter int DILATION    = 1,
    parameter int STRIDE      = 1,
    parameter int ACC_W       = 2*DATA_W+8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     sat_en,
    input  logic signed [DATA_W-1:0] input_data [IN_DEPTH][IN_HEIGHT][IN_WIDTH],
    input  logic signed [DATA_W-1:0] kernels [KERNEL_SIZE][KERNEL_SIZE][IN_DEPTH][OUT_DEPTH],
    input  logic signed [DATA_W-1:0] biases [OUT_DEPTH],
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] output_data [OUT_DEPTH][(IN_HEIGHT+STRIDE-1)/STRIDE][(IN_WIDTH+STRIDE-1)/STRIDE]
);

    localparam int OUT_H = (IN_HEIGHT + STRIDE - 1) / STRIDE;
    localparam int OUT_W = (IN_WIDTH + STRIDE - 1) / STRIDE;
    localparam int PAD   = (KERNEL_SIZE / 2) * DILATION;

    localparam int CI_W  = (IN_DEPTH    > 1) ? $clog2(IN_DEPTH)    : 1;
    localparam int K_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int OC_W  = (OUT_DEPTH   > 1) ? $clog2(OUT_DEPTH)   : 1;
    localparam int OH_W  = (OUT_H       > 1) ? $clog2(OUT_H)       : 1;
    localparam int OW_W  = (OUT_W       > 1) ? $clog2(OUT_W)       : 1;
    localparam int ROW_W = (IN_HEIGHT   > 1) ? $clog2(IN_HEIGHT)   : 1;
    localparam int COL_W = (IN_WIDTH    > 1) ? $clog2(IN_WIDTH)    : 1;

    localparam logic [CI_W-1:0] CI_LAST = CI_W'(IN_DEPTH - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL_SIZE - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_DEPTH - 1);
    localparam logic [OH_W-1:0] OH_LAST = OH_W'(OUT_H - 1);
    localparam logic [OW_W-1:0] OW_LAST = OW_W'(OUT_W - 1);

    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [OC_W-1:0]            cout_q, cout_d;
    logic [OH_W-1:0]            oh_q, oh_d;
    logic [OW_W-1:0]            ow_q, ow_d;
    logic [CI_W-1:0]            cin_q, cin_d;
    logic [K_W-1:0]             m_q, m_d;
    logic [K_W-1:0]             n_q, n_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       relu_q, relu_d;
    logic                       sat_q, sat_d;
    logic signed [DATA_W-1:0]   out_q [OUT_DEPTH][OUT_H][OUT_W];
    logic signed [DATA_W-1:0]   out_d [OUT_DEPTH][OUT_H][OUT_W];

    int                         ir, ic;
    logic                       in_bounds;
    logic signed [DATA_W-1:0]   data_tap, weight;
    logic signed [2*DATA_W-1:0] prod;
    logic                       first_tap;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   res;

    // Tap fetch: padded positions contribute a zero product but still take their cycle.
    always_comb begin
        ir        = int'(oh_q) * STRIDE + int'(m_q) * DILATION - PAD;
        ic        = int'(ow_q) * STRIDE + int'(n_q) * DILATION - PAD;
        in_bounds = (ir >= 0) && (ir < IN_HEIGHT) && (ic >= 0) && (ic < IN_WIDTH);
        data_tap  = '0;
        if (in_bounds) begin
            data_tap = input_data[cin_q][ROW_W'(ir)][COL_W'(ic)];
        end
        weight    = kernels[m_q][n_q][cin_q][cout_q];
        prod      = (2*DATA_W)'(data_tap) * (2*DATA_W)'(weight);
        first_tap = (cin_q == '0) && (m_q == '0) && (n_q == '0);
    end

    always_comb begin
        shifted = acc_q >>> FRAC;
        if (relu_q && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        res = shifted[DATA_W-1:0];
        if (sat_q) begin
            if (shifted > S_MAX) begin
                res = S_MAX[DATA_W-1:0];
            end else if (shifted < S_MIN) begin
                res = S_MIN[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cout_d  = cout_q;
        oh_d    = oh_q;
        ow_d    = ow_q;
        cin_d   = cin_q;
        m_d     = m_q;
        n_d     = n_q;
        acc_d   = acc_q;
        relu_d  = relu_q;
        sat_d   = sat_q;
        out_d   = out_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    relu_d  = relu_en;
                    sat_d   = sat_en;
                    cout_d  = '0;
                    oh_d    = '0;
                    ow_d    = '0;
                    cin_d   = '0;
                    m_d     = '0;
                    n_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = (first_tap ? ACC_W'(biases[cout_q]) : acc_q) + ACC_W'(prod);
                if (n_q == K_LAST) begin
                    n_d = '0;
                    if (m_q == K_LAST) begin
                        m_d = '0;
                        if (cin_q == CI_LAST) begin
                            cin_d   = '0;
                            state_d = S_WRITE;
                        end else begin
                            cin_d = cin_q + CI_W'(1);
                        end
                    end else begin
                        m_d = m_q + K_W'(1);
                    end
                end else begin
                    n_d = n_q + K_W'(1);
                end
            end
            S_WRITE: begin
                out_d[cout_q][oh_q][ow_q] = res;
                state_d = S_MAC;
                if (ow_q == OW_LAST) begin
                    ow_d = '0;
                    if (oh_q == OH_LAST) begin
                        oh_d = '0;
                        if (cout_q == OC_LAST) begin
                            cout_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            cout_d = cout_q + OC_W'(1);
                        end
                    end else begin
                        oh_d = oh_q + OH_W'(1);
                    end
                end else begin
                    ow_d = ow_q + OW_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cout_q  <= '0;
            oh_q    <= '0;
            ow_q    <= '0;
            cin_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            relu_q  <= 1'b0;
            sat_q   <= 1'b0;
            // NOTE: the result array is flop-based and must read as zero after reset, so it is cleared here rather than left uninitialised like a RAM.
            for (int o = 0; o < OUT_DEPTH; o++) begin
                for (int h = 0; h < OUT_H; h++) begin
                    for (int w = 0; w < OUT_W; w++) begin
                        out_q[o][h][w] <= '0;
                    end
                end
            end
        end else begin
            state_q <= state_d;
            cout_q  <= cout_d;
            oh_q    <= oh_d;
            ow_q    <= ow_d;
            cin_q   <= cin_d;
            m_q     <= m_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            relu_q  <= relu_d;
            sat_q   <= sat_d;
            out_q   <= out_d;
        end
    end

    assign busy        = (state_q == S_MAC) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign output_data = out_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: default layer driven from a vector table, plus
// stride-2 and dilation-2 instances and a reset/abort/ignored-start sequence.
module tb_conv_layer_seq;

    logic clk = 1'b0;
    logic rst;
    logic relu_en, sat_en;
    logic start_a, start_s, start_d;
    logic busy_a, busy_s, busy_d;
    logic done_a, done_s, done_d;

    logic signed [15:0] data_a [3][4][4];
    logic signed [15:0] ker_a  [3][3][3][2];
    logic signed [15:0] bias_a [2];
    logic signed [15:0] out_a  [2][4][4];

    logic signed [15:0] data_s [1][4][4];
    logic signed [15:0] ker_s  [3][3][1][1];
    logic signed [15:0] bias_s [1];
    logic signed [15:0] out_s  [1][2][2];

    logic signed [15:0] data_d [1][4][4];
    logic signed [15:0] ker_d  [3][3][1][1];
    logic signed [15:0] bias_d [1];
    logic signed [15:0] out_d  [1][4][4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_layer_seq dut_a (
        .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_en), .sat_en(sat_en),
        .input_data(data_a), .kernels(ker_a), .biases(bias_a),
        .busy(busy_a), .done(done_a), .output_data(out_a)
    );

    conv_layer_seq #(.IN_DEPTH(1), .OUT_DEPTH(1), .STRIDE(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .relu_en(relu_en), .sat_en(sat_en),
        .input_data(data_s), .kernels(ker_s), .biases(bias_s),
        .busy(busy_s), .done(done_s), .output_data(out_s)
    );

    conv_layer_seq #(.IN_DEPTH(1), .OUT_DEPTH(1), .DILATION(2)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .relu_en(relu_en), .sat_en(sat_en),
        .input_data(data_d), .kernels(ker_d), .biases(bias_d),
        .busy(busy_d), .done(done_d), .output_data(out_d)
    );

    typedef struct {
        string name;
        int    din, kval, b0, b1;
        int    relu, sat;
        int    ec0, ee0, ei0, ec1, ee1, ei1;
    } vec_t;

    vec_t tbl [8];

    // Sample points of the 4x4 map: class 0 corner, 1 edge, 2 interior.
    int pr   [11] = '{0, 0, 3, 3, 0, 1, 3, 2, 1, 2, 1};
    int pc   [11] = '{0, 3, 0, 3, 1, 0, 2, 3, 1, 2, 2};
    int pcls [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_s;
            default: return done_d;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_s;
            default: return busy_d;
        endcase
    endfunction

    function automatic int exp_of(input vec_t v, input int ch, input int cls);
        int e [6];
        e = '{v.ec0, v.ee0, v.ei0, v.ec1, v.ee1, v.ei1};
        return e[ch*3 + cls];
    endfunction

    task automatic fill_a(input int din, input int kval, input int b0, input int b1);
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                for (int w = 0; w < 4; w++)
                    data_a[c][r][w] = 16'(din);
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                for (int c = 0; c < 3; c++)
                    for (int o = 0; o < 2; o++)
                        ker_a[m][n][c][o] = 16'(kval);
        bias_a[0] = 16'(b0);
        bias_a[1] = 16'(b1);
    endtask

    // Start a run, flip the mode inputs after they are sampled, and measure start-to-done.
    task automatic run_layer(input int sel, input int exp_cycles, input string name);
        int cyc;
        cyc = 0;
        case (sel)
            0:       start_a = 1'b1;
            1:       start_s = 1'b1;
            default: start_d = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_s = 1'b0;
        start_d = 1'b0;
        relu_en = ~relu_en;
        sat_en  = ~sat_en;
        while (done_of(sel) !== 1'b1 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check({name, " latency"}, cyc, exp_cycles);
        check({name, " busy_at_done"}, busy_of(sel), 0);
        tick();
        check({name, " done_single_pulse"}, done_of(sel), 0);
    endtask

    initial begin
        int cyc;
        int nz;
        logic seen;

        // Products of 0x7FFF taps: (n*32767^2)>>>4 low 16 bits for n = 12/18/27 are 16384/-8191/20481.
        tbl[0] = '{"pos",      16,     16,     0,    0,   0, 0,    192,    288,    432,    192,    288,    432};
        tbl[1] = '{"bias",     16,     16,   256, -256,   0, 0,    208,    304,    448,    176,    272,    416};
        tbl[2] = '{"relu_neg", 16,    -16,     0,    0,   1, 0,      0,      0,      0,      0,      0,      0};
        tbl[3] = '{"neg",      16,    -16,     0,    0,   0, 0,   -192,   -288,   -432,   -192,   -288,   -432};
        tbl[4] = '{"sat_pos",  32767,  32767,  0,    0,   0, 1,  32767,  32767,  32767,  32767,  32767,  32767};
        tbl[5] = '{"wrap",     32767,  32767,  0,    0,   0, 0,  16384,  -8191,  20481,  16384,  -8191,  20481};
        tbl[6] = '{"floor",    1,      -1,     0,    0,   0, 0,     -1,     -2,     -2,     -1,     -2,     -2};
        tbl[7] = '{"sat_neg",  32767, -32767,  0,    0,   0, 1, -32768, -32768, -32768, -32768, -32768, -32768};

        rst = 1'b1;
        start_a = 1'b0;
        start_s = 1'b0;
        start_d = 1'b0;
        relu_en = 1'b0;
        sat_en  = 1'b0;
        fill_a(0, 0, 0, 0);
        for (int r = 0; r < 4; r++)
            for (int w = 0; w < 4; w++) begin
                data_s[0][r][w] = 16'(16 * (r*4 + w));
                data_d[0][r][w] = 16'sd16;
            end
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++) begin
                ker_s[m][n][0][0] = (m == 1 && n == 1) ? 16'sd16 : 16'sd0;
                ker_d[m][n][0][0] = 16'sd16;
            end
        bias_s[0] = 16'sd0;
        bias_d[0] = 16'sd0;
        tick();
        tick();
        rst = 1'b0;

        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset out_a[1][3][3]", out_a[1][3][3], 0);
        check("reset out_s[0][1][1]", out_s[0][1][1], 0);
        tick();
        check("idle without start", busy_a, 0);

        for (int v = 0; v < 8; v++) begin
            fill_a(tbl[v].din, tbl[v].kval, tbl[v].b0, tbl[v].b1);
            relu_en = (tbl[v].relu != 0);
            sat_en  = (tbl[v].sat != 0);
            run_layer(0, 896, tbl[v].name);
            for (int ch = 0; ch < 2; ch++)
                for (int p = 0; p < 11; p++)
                    check($sformatf("%s out[%0d][%0d][%0d]", tbl[v].name, ch, pr[p], pc[p]),
                          out_a[ch][pr[p]][pc[p]], exp_of(tbl[v], ch, pcls[p]));
        end

        relu_en = 1'b0;
        sat_en  = 1'b0;
        run_layer(1, 40, "stride2");
        check("stride2 out[0][0]", out_s[0][0][0], 0);
        check("stride2 out[0][1]", out_s[0][0][1], 32);
        check("stride2 out[1][0]", out_s[0][1][0], 128);
        check("stride2 out[1][1]", out_s[0][1][1], 160);

        relu_en = 1'b0;
        sat_en  = 1'b0;
        run_layer(2, 160, "dilation2");
        check("dilation2 out[0][0]", out_d[0][0][0], 64);
        check("dilation2 out[1][1]", out_d[0][1][1], 64);
        check("dilation2 out[2][2]", out_d[0][2][2], 64);
        check("dilation2 out[0][1]", out_d[0][0][1], 64);

        // Hold of stale elements, then abort by reset at cycle 100.
        fill_a(16, 16, 0, 0);
        relu_en = 1'b0;
        sat_en  = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 40) begin
                check("partial run busy", busy_a, 1);
                check("partial run new pixel", out_a[0][0][0], 192);
                check("partial run stale pixel", out_a[0][0][1], tbl[7].ee0);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy_a, 0);
        check("abort done", done_a, 0);
        nz = 0;
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 4; r++)
                for (int w = 0; w < 4; w++)
                    if (out_a[o][r][w] !== 16'sd0) nz++;
        check("abort outputs cleared", nz, 0);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen = 1'b1;
        end
        check("abort no done pulse", seen, 0);

        // Restart; a start pulsed mid-run must not change the run length.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 5000) begin
            if (cyc == 300) start_a = 1'b1;
            tick();
            start_a = 1'b0;
            cyc++;
        end
        check("restart latency", cyc, 896);
        check("restart out[1][3][3]", out_a[1][3][3], 192);
        check("restart out[1][1][2]", out_a[1][1][2], 432);
        tick();
        check("restart back to idle", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
Sequential, parametrised successor to the combinational convolution layer. It computes a zero-padded ("same") 2-D convolution with bias, fixed-point shift, dilation, stride, optional ReLU and optional saturation. It uses one multiply-accumulate per clock under a start/done handshake, so a single multiplier can serve the whole layer. It sits between the input feature-map buffer and the next layer; its registered output array is stable after done.

Parameters:
IN_DEPTH, 3, input channels
IN_HEIGHT, 4, input rows
IN_WIDTH, 4, input columns
OUT_DEPTH, 2, output channels (filters)
KERNEL_SIZE, 3, square kernel side, odd
DATA_W, 16, signed data/weight/bias width
FRAC, 4, fractional bits; result = acc >>> FRAC
DILATION, 1, kernel tap spacing, >=1
STRIDE, 1, output sampling step, >=1
ACC_W, 2*DATA_W+8, signed accumulator width

Derived values:
- OUT_H = (IN_HEIGHT+STRIDE-1)/STRIDE
- OUT_W = (IN_WIDTH+STRIDE-1)/STRIDE
- PAD = (KERNEL_SIZE/2)*DILATION

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a layer computation; sampled only in IDLE
relu_en  in  1  clamp negative results to 0; sampled with start
sat_en  in  1  saturate instead of truncate; sampled with start
input_data  in  DATA_W x [IN_DEPTH][IN_HEIGHT][IN_WIDTH]  signed feature map; must be stable while busy
kernels  in  DATA_W x [K][K][IN_DEPTH][OUT_DEPTH]  signed weights; must be stable while busy
biases  in  DATA_W x [OUT_DEPTH]  signed per-filter bias; must be stable while busy
busy  out  1  computation in progress
done  out  1  single-cycle completion pulse
output_data  out  DATA_W x [OUT_DEPTH][OUT_H][OUT_W]  signed registered results

Behaviour:
- Reset (rst high at an edge):
  - State returns to IDLE; busy=0, done=0, all output_data=0, counters and accumulator cleared.
  - Reset mid-operation aborts the run: no done pulse, and outputs are cleared.
- States: IDLE -> MAC <-> WRITE -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge: latch relu_en/sat_en, zero the counters, go to MAC, busy=1 from the next cycle.
  - start=0: stay in IDLE.
- Output loop order: cout outermost, then oh, then ow. Tap order: cin, then m, then n (n innermost).
- MAC: one tap per cycle, IN_DEPTH*K*K cycles per output pixel.
  - First tap: acc = sext(bias[cout]) + product. Later taps: acc += product.
  - Tap input position: ir = oh*STRIDE + m*DILATION - PAD, ic = ow*STRIDE + n*DILATION - PAD.
  - If the position falls outside the map, the product is 0 but the cycle is still spent, so latency is fixed.
  - Products are full 2*DATA_W signed, sign-extended to ACC_W.
- WRITE (1 cycle): compute s = acc >>> FRAC (arithmetic).
  - If relu_en and s<0, then s=0.
  - If sat_en, clamp s to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; otherwise take the low DATA_W bits.
  - Write s to output_data[cout][oh][ow], then advance the pixel counters. After the last pixel go to DONE, else return to MAC.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Latency:
  - T = IN_DEPTH*K*K+1 cycles per pixel; P = OUT_DEPTH*OUT_H*OUT_W pixels.
  - If start is sampled at edge E, done is high in the cycle after edge E+P*T; busy is high for exactly P*T cycles before that.
- start while busy or in DONE is ignored, with no queuing. start is accepted again in IDLE, at the earliest the cycle after done.
- output_data holds each value until that element is rewritten. Elements not yet rewritten in a new run keep their previous values.
- Changing relu_en/sat_en mid-run has no effect.

Test Plan:
- Defaults; all inputs 16, all kernels 16, biases 0, relu/sat off -> done exactly 896 cycles after start. Each channel: corners 192, edges 288, interior 432.
- Same data with kernels -16, relu_en=1 -> all outputs 0. relu_en=0 -> corners -192, interior -432.
- Inputs and kernels 0x7FFF, K=3, IN_DEPTH=3: sat_en=1 -> interior 32767. sat_en=0 -> interior equals the low 16 bits of (27*32767^2)>>>4.
- STRIDE=2, 1 channel in/out, 4x4 ramp input (value = 16*(r*4+c)), identity kernel (centre 16, others 0) -> 2x2 output {0,32,128,160}, done after 4*10 cycles.
- DILATION=2, 4x4 all 16, K=3, 1 channel, kernels 16 -> output[0][0] = 4 taps = 64, output[1][1] = 64, output[2][2] = 64 (only in-bounds taps counted).
- Reset at cycle 100 of a run -> busy/done 0 and outputs 0 the next cycle, no done pulse. Re-start then completes normally; a start pulsed mid-run is ignored and the run length is unchanged.
